// File: rtl/acia_rx_fifo.sv
// Receive FIFO for an ACIA: stores {err, byte} entries from the receiver and
// presents the head entry first-word-fall-through to the CPU register logic.
module acia_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_stb,
  input  logic [7:0]    wr_dat,
  input  logic          wr_err,
  input  logic          rd,
  output logic [7:0]    rd_dat,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   thresh,
  output logic          irq,
  output logic          ovr,
  input  logic          clr_ovr
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          push;
  logic          pop;
  logic          overrun;

  // Handshake: wr_stb is a single-cycle strobe with no back-pressure; a byte
  // offered while full is dropped unless rd frees a slot in the same cycle.
  // rd pops the head when not empty and is ignored when empty.
  assign push    = wr_stb & (~full | rd);
  assign pop     = rd & ~empty;
  assign overrun = wr_stb & full & ~rd;

  assign empty  = (level == '0);
  assign full   = (level == FULL_LVL);
  assign rd_dat = empty ? 8'h00 : mem[rd_ptr][7:0];
  assign rd_err = empty ? 1'b0  : mem[rd_ptr][8];

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + 1'b1;
    else if (pop && !push)
      level_next = level - 1'b1;
  end

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push)
      mem[wr_ptr] <= {wr_err, wr_dat};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovr    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      if (overrun)
        ovr <= 1'b1;
      else if (clr_ovr)
        ovr <= 1'b0;
      // Threshold is compared against the post-update level so irq tracks level.
      irq <= (thresh != '0) && (level_next >= thresh);
    end
  end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo (DEPTH=16): fill/drain, overrun, threshold
// interrupt, pointer wrap and mid-operation reset.
module tb_acia_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_stb;
  logic [7:0] wr_dat;
  logic       wr_err;
  logic       rd;
  logic [7:0] rd_dat;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic [4:0] thresh;
  logic       irq;
  logic       ovr;
  logic       clr_ovr;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  acia_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_dat(wr_dat), .wr_err(wr_err),
    .rd(rd), .rd_dat(rd_dat), .rd_err(rd_err), .empty(empty), .full(full),
    .level(level), .thresh(thresh), .irq(irq), .ovr(ovr), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    wr_stb = 1'b1; wr_dat = d; wr_err = e;
    tick();
    wr_stb = 1'b0; wr_err = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_stb = 1'b0; wr_dat = 8'h00; wr_err = 1'b0;
    rd = 1'b0; thresh = 5'd0; clr_ovr = 1'b0;
    tick(); tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_dat", rd_dat, 8'h00);

    // First push lands on the first edge with reset released
    rst = 1'b1;
    push(8'h41, 1'b0);
    chk("first_push_level", level, 1);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    chk("abc_level", level, 3);
    chk("abc_head", rd_dat, 8'h41);
    pop();
    chk("abc_pop1", rd_dat, 8'h42);
    pop();
    chk("abc_pop2", rd_dat, 8'h43);
    pop();
    chk("abc_empty", empty, 1);
    chk("abc_empty_dat", rd_dat, 8'h00);
    chk("abc_empty_level", level, 0);

    // Fill, overrun, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_ovr", ovr, 0);
    push(8'hAA, 1'b0);
    chk("ovr_set", ovr, 1);
    chk("ovr_level", level, 16);
    chk("ovr_head", rd_dat, 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), rd_dat, 8'(i));
      pop();
    end
    chk("drain_empty", empty, 1);
    chk("ovr_sticky", ovr, 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("ovr_clr", ovr, 0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    wr_stb = 1'b1; wr_dat = 8'h55; rd = 1'b1;
    tick();
    wr_stb = 1'b0; rd = 1'b0;
    chk("fullrw_level", level, 16);
    chk("fullrw_ovr", ovr, 0);
    chk("fullrw_full", full, 1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fullrw_pop_%0d", i), rd_dat, 8'(8'h10 + i));
      pop();
    end
    chk("fullrw_last", rd_dat, 8'h55);
    pop();
    chk("fullrw_empty", empty, 1);

    // Threshold interrupt
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 1'b0);
    tick();
    chk("irq_below", irq, 0);
    push(8'h23, 1'b0);
    tick();
    chk("irq_at", irq, 1);
    pop();
    tick();
    chk("irq_after_pop", irq, 0);
    thresh = 5'd0;
    for (int i = 0; i < 13; i++) push(8'(8'h30 + i), 1'b0);
    tick();
    chk("irq_dis_full", full, 1);
    chk("irq_disabled", irq, 0);
    thresh = 5'd17;
    tick(); tick();
    chk("irq_thresh_gt_depth", irq, 0);
    thresh = 5'd16;
    tick(); tick();
    chk("irq_thresh_depth", irq, 1);
    // Overrun wins over a same-cycle clear
    wr_stb = 1'b1; wr_dat = 8'hEE; clr_ovr = 1'b1;
    tick();
    wr_stb = 1'b0; clr_ovr = 1'b0;
    chk("ovr_beats_clr", ovr, 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("ovr_clr2", ovr, 0);
    thresh = 5'd0;
    for (int i = 0; i < 16; i++) pop();
    chk("irq_drain_empty", empty, 1);

    // Error flag, rd on empty, push+rd on empty
    push(8'h7E, 1'b1);
    chk("err_flag", rd_err, 1);
    chk("err_dat", rd_dat, 8'h7E);
    pop();
    chk("err_empty_flag", rd_err, 0);
    pop();
    chk("rd_empty_level", level, 0);
    chk("rd_empty_empty", empty, 1);
    wr_stb = 1'b1; wr_dat = 8'h99; rd = 1'b1;
    tick();
    wr_stb = 1'b0; rd = 1'b0;
    chk("pushrd_empty_level", level, 1);
    chk("pushrd_empty_dat", rd_dat, 8'h99);
    exp_q.push_back({1'b0, 8'h99});

    // 40 push/pop cycles at level 1, crossing the pointer wrap
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       e;
      d = 8'($urandom_range(0, 255));
      e = 1'($urandom_range(0, 1));
      wr_stb = 1'b1; wr_dat = d; wr_err = e; rd = 1'b1;
      tick();
      wr_stb = 1'b0; wr_err = 1'b0; rd = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({e, d});
      chk($sformatf("wrap_dat_%0d", i), rd_dat, exp_q[0][7:0]);
      chk($sformatf("wrap_err_%0d", i), rd_err, exp_q[0][8]);
      chk($sformatf("wrap_level_%0d", i), level, 1);
    end
    pop();
    chk("wrap_empty", empty, 1);

    // Mid-operation reset with a strobe during reset
    thresh = 5'd4;
    for (int i = 0; i < 10; i++) push(8'(8'h60 + i), 1'b0);
    tick();
    chk("pre_rst_level", level, 10);
    chk("pre_rst_irq", irq, 1);
    rst = 1'b0; wr_stb = 1'b1; wr_dat = 8'hBB; rd = 1'b1;
    tick();
    rst = 1'b1; wr_stb = 1'b0; rd = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_irq", irq, 0);
    push(8'h33, 1'b0);
    chk("post_rst_dat", rd_dat, 8'h33);
    chk("post_rst_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acia_rx_fifo.md
ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of receive entries (power of 2, 4..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port wr_stb  in  1  one-cycle strobe from the receiver: byte available.
REQ-006 SHALL have port wr_dat  in  8  received byte, qualified by wr_stb.
REQ-007 SHALL have port wr_err  in  1  receiver error flag, qualified by wr_stb, stored with the byte.
REQ-008 SHALL have port rd  in  1  pop request from the CPU-side register logic.
REQ-009 SHALL have port rd_dat  out  8  head-entry byte, first-word-fall-through.
REQ-010 SHALL have port rd_err  out  1  error flag stored with the head entry.
REQ-011 SHALL have port empty  out  1  no entries held.
REQ-012 SHALL have port full  out  1  DEPTH entries held.
REQ-013 SHALL have port level  out  AW+1  current entry count, 0..DEPTH.
REQ-014 SHALL have port thresh  in  AW+1  interrupt fill threshold; 0 disables.
REQ-015 SHALL have port irq  out  1  high-true fill-threshold interrupt.
REQ-016 SHALL have port ovr  out  1  sticky overrun flag.
REQ-017 SHALL have port clr_ovr  in  1  one-cycle clear of ovr.

Function
REQ-018 SHALL store 9-bit entries {wr_err, wr_dat} in a DEPTH-deep circular buffer with AW-bit write/read pointers wrapping DEPTH-1 -> 0.
REQ-019 SHALL push on a wr_stb cycle when not full, or when full with rd asserted the same cycle.
REQ-020 SHALL pop on a rd cycle only when not empty; rd while empty SHALL be ignored (no pointer/level change).
REQ-021 SHALL, on simultaneous push and pop, advance both pointers and leave level unchanged, including at full (no overrun) and at level 1.
REQ-022 SHALL, on wr_stb & empty & rd, perform the push only; level becomes 1.
REQ-023 SHALL, on wr_stb while full without rd, drop the byte, leave buffer contents and pointers unchanged, and set ovr.
REQ-024 SHALL hold ovr set until clr_ovr or reset; overrun set SHALL win over clr_ovr in the same cycle.
REQ-025 SHALL update level, empty, full one cycle after the push/pop edge (registered), with empty = (level==0) and full = (level==DEPTH).
REQ-026 SHALL present rd_dat/rd_err combinationally from the head entry when not empty; when empty both SHALL read 0.
REQ-027 SHALL make a byte pushed at edge N visible on rd_dat after edge N (zero extra latency to head).
REQ-028 SHALL drive irq as registered (thresh != 0) & (level >= thresh), evaluated on post-update level, so irq follows level by at most one cycle.
REQ-029 SHALL treat thresh > DEPTH as never asserting irq.

Reset
REQ-030 SHALL, while rst==0 at a clock edge, clear both pointers, level=0, empty=1, full=0, ovr=0, irq=0; buffer contents SHALL not be reset.
REQ-031 SHALL, on reset mid-operation, discard all held entries; wr_stb/rd during reset SHALL be ignored.
REQ-032 SHALL accept the first push on the first edge with rst==1.

Verification
REQ-033 Reset then push 0x41,0x42,0x43 (wr_err=0) -> level=3, rd_dat=0x41; three rd pulses -> 0x42, 0x43, then empty=1, rd_dat=0x00.
REQ-034 Push 16 bytes 0x00..0x0F -> full=1, level=16; 17th push 0xAA -> ovr=1, contents unchanged; drain returns 0x00..0x0F in order; clr_ovr -> ovr=0.
REQ-035 At full, wr_stb 0x55 with rd same cycle -> level stays 16, ovr=0, 0x55 read last after 15 more pops.
REQ-036 thresh=4: push 3 -> irq=0; 4th push -> irq=1 within one cycle; one pop -> irq=0; thresh=0 with 16 entries -> irq=0.
REQ-037 Push 0x7E with wr_err=1 -> rd_err=1 with rd_dat=0x7E; rd on empty -> level stays 0; 40 push/pop cycles across pointer wrap -> data in order, level exact.
REQ-038 Fill to 10 entries, assert rst=0 one cycle -> empty=1, level=0, ovr=0, irq=0; next push 0x33 -> rd_dat=0x33.
